spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 130 +++++++++++++
 tb/tb_spi_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: one byte per transfer, MSB first, SPI mode and SPI clock rate set by parameters.
// Optional build macro SPI_MASTER_LOOPBACK_EN feeds o_SPI_MOSI back into the receive path in place of i_SPI_MISO.
module spi_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Rst_L,
    input  logic       i_Clk,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);

    localparam logic CPOL  = ((SPI_MODE >> 1) & 1) != 0;
    localparam logic CPHA  = (SPI_MODE & 1) != 0;
    localparam int   CNT_W = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_tx_ready;
    logic             r_rx_dv;
    logic [7:0]       r_rx_byte;
    logic [7:0]       r_tx_shift;
    logic [7:0]       r_rx_shift;
    logic             r_spi_clk;
    logic             r_mosi;
    logic [CNT_W-1:0] r_half_cnt;
    logic [3:0]       r_edge_cnt;

    logic w_miso;
    logic w_half_done;
    logic w_leading;
    logic w_sample;
    logic w_launch;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_miso = r_mosi;
`else
    assign w_miso = i_SPI_MISO;
`endif

    // r_edge_cnt holds the number of edges already issued, so an even count means the next edge is leading.
    assign w_half_done = (r_half_cnt == HALF_LAST);
    assign w_leading   = (r_edge_cnt[0] == 1'b0);
    assign w_sample    = (r_edge_cnt[0] == CPHA);
    // With CPHA=0 bit 7 goes out at accept, so the last trailing edge launches nothing.
    assign w_launch    = CPHA ? w_leading : (!w_leading && (r_edge_cnt != 4'd15));

    // NOTE: every register here is state updated on the clock edge, so all assignments are non-blocking.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L) begin
            r_state    <= S_IDLE;
            r_tx_ready <= 1'b0;
            r_rx_dv    <= 1'b0;
            r_rx_byte  <= 8'h00;
            r_tx_shift <= 8'h00;
            r_rx_shift <= 8'h00;
            r_spi_clk  <= CPOL;
            r_mosi     <= 1'b0;
            r_half_cnt <= '0;
            r_edge_cnt <= 4'd0;
        end else begin
            r_rx_dv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_tx_ready) begin
                        r_tx_ready <= 1'b1;
                    end else if (i_TX_DV) begin
                        r_tx_ready <= 1'b0;
                        r_state    <= S_XFER;
                        r_half_cnt <= '0;
                        r_edge_cnt <= 4'd0;
                        if (!CPHA) begin
                            r_mosi     <= i_TX_Byte[7];
                            r_tx_shift <= {i_TX_Byte[6:0], 1'b0};
                        end else begin
                            r_tx_shift <= i_TX_Byte;
                        end
                    end
                end
                S_XFER: begin
                    if (w_half_done) begin
                        r_half_cnt <= '0;
                        r_spi_clk  <= ~r_spi_clk;
                        r_edge_cnt <= r_edge_cnt + 4'd1;
                        if (w_sample) begin
                            r_rx_shift <= {r_rx_shift[6:0], w_miso};
                        end
                        if (w_launch) begin
                            r_mosi     <= r_tx_shift[7];
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        end
                        if (r_edge_cnt == 4'd15) begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_rx_byte  <= r_rx_shift;
                    r_rx_dv    <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_TX_Ready = r_tx_ready;
    assign o_RX_DV    = r_rx_dv;
    assign o_RX_Byte  = r_rx_byte;
    assign o_SPI_Clk  = r_spi_clk;
    assign o_SPI_MOSI = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance per SPI mode, each with a small SPI slave model driving MISO.
module tb_spi_master;

    logic       clk;
    logic       rst;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic [3:0] tx_ready;
    logic [3:0] rx_dv;
    logic [3:0] spi_clk;
    logic [3:0] mosi;
    logic [7:0] rx_byte [4];
    logic [7:0] pat;

    int n_pass;
    int n_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int CPHA_M = m % 2;

        logic       miso_b;
        logic       prev_clk;
        logic       prev_ready;
        int         edge_n;
        logic [7:0] mosi_cap;

        spi_master #(
            .SPI_MODE         (m),
            .CLKS_PER_HALF_BIT(2)
        ) u_dut (
            .i_Rst_L   (rst),
            .i_Clk     (clk),
            .i_TX_Byte (tx_byte),
            .i_TX_DV   (tx_dv),
            .o_TX_Ready(tx_ready[m]),
            .o_RX_DV   (rx_dv[m]),
            .o_RX_Byte (rx_byte[m]),
            .o_SPI_Clk (spi_clk[m]),
            .i_SPI_MISO(miso_b),
            .o_SPI_MOSI(mosi[m])
        );

        // Slave: presents pat MSB first on its launch edges and records MOSI on its sample edges.
        always @(negedge clk) begin
            prev_clk   <= spi_clk[m];
            prev_ready <= tx_ready[m];
            if (tx_ready[m] === 1'b1 || rst === 1'b1) begin
                edge_n <= 0;
                miso_b <= pat[7];
            end else if (spi_clk[m] !== prev_clk) begin
                edge_n <= edge_n + 1;
                if (CPHA_M == 0 && (edge_n % 2) == 1 && edge_n < 15)
                    miso_b <= pat[7 - (edge_n + 1) / 2];
                if (CPHA_M == 1 && (edge_n % 2) == 0)
                    miso_b <= pat[7 - edge_n / 2];
                if ((edge_n % 2) == CPHA_M)
                    mosi_cap <= {mosi_cap[6:0], mosi[m]};
            end
            if (prev_ready === 1'b1 && tx_ready[m] === 1'b0 && rst === 1'b0)
                mosi_cap <= 8'h00;
        end
    end

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] p);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return p;
`endif
    endfunction

    task automatic test_reset();
        rst     = 1'b1;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        pat     = 8'h00;
        repeat (3) @(negedge clk);
        n_total++; if (tx_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", tx_ready); else n_pass++;
        n_total++; if (rx_dv !== 4'b0000) $display("FAIL reset_rx_dv got=%b exp=0000", rx_dv); else n_pass++;
        n_total++; if (mosi !== 4'b0000) $display("FAIL reset_mosi got=%b exp=0000", mosi); else n_pass++;
        n_total++; if (spi_clk !== 4'b1100) $display("FAIL reset_spi_clk got=%b exp=1100", spi_clk); else n_pass++;
        n_total++; if (rx_byte[0] !== 8'h00) $display("FAIL reset_rx_byte0 got=%h exp=00", rx_byte[0]); else n_pass++;
        n_total++; if (rx_byte[3] !== 8'h00) $display("FAIL reset_rx_byte3 got=%h exp=00", rx_byte[3]); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (tx_ready !== 4'b1111) $display("FAIL release_ready got=%b exp=1111", tx_ready); else n_pass++;
    endtask

    // Mode 0 timing, byte latching and back-to-back transfer with DV held high.
    task automatic test_mode0_back_to_back();
        int first_dv;
        first_dv = 0;
        pat     = 8'hFF;
        tx_byte = 8'hAB;
        tx_dv   = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (rx_dv[0] === 1'b1 && first_dv == 0) first_dv = k;
            if (k == 1) begin
                n_total++; if (tx_ready[0] !== 1'b0) $display("FAIL m0_busy got=%b exp=0", tx_ready[0]); else n_pass++;
                n_total++; if (mosi[0] !== 1'b1) $display("FAIL m0_first_bit got=%b exp=1", mosi[0]); else n_pass++;
            end
            if (k == 2) begin
                n_total++; if (spi_clk[0] !== 1'b0) $display("FAIL m0_clk_before_edge got=%b exp=0", spi_clk[0]); else n_pass++;
            end
            if (k == 3) begin
                n_total++; if (spi_clk[0] !== 1'b1) $display("FAIL m0_first_edge got=%b exp=1", spi_clk[0]); else n_pass++;
            end
            if (k == 5) tx_byte = 8'h56;
            if (k == 34) begin
                n_total++; if (rx_dv[0] !== 1'b1) $display("FAIL m0_rx_dv got=%b exp=1", rx_dv[0]); else n_pass++;
                n_total++; if (tx_ready[0] !== 1'b1) $display("FAIL m0_ready_back got=%b exp=1", tx_ready[0]); else n_pass++;
                n_total++; if (spi_clk[0] !== 1'b0) $display("FAIL m0_idle_clk got=%b exp=0", spi_clk[0]); else n_pass++;
                n_total++; if (rx_byte[0] !== exp_rx(8'hAB, 8'hFF)) $display("FAIL m0_rx_byte got=%h exp=%h", rx_byte[0], exp_rx(8'hAB, 8'hFF)); else n_pass++;
                n_total++; if (g_mode[0].mosi_cap !== 8'hAB) $display("FAIL m0_mosi_bits got=%h exp=ab", g_mode[0].mosi_cap); else n_pass++;
                n_total++; if (g_mode[0].edge_n !== 16) $display("FAIL m0_edge_count got=%0d exp=16", g_mode[0].edge_n); else n_pass++;
            end
            if (k == 35) begin
                n_total++; if (rx_dv[0] !== 1'b0) $display("FAIL m0_dv_one_cycle got=%b exp=0", rx_dv[0]); else n_pass++;
                n_total++; if (tx_ready[0] !== 1'b0) $display("FAIL m0_b2b_accept got=%b exp=0", tx_ready[0]); else n_pass++;
                tx_dv = 1'b0;
            end
            if (k == 68) begin
                n_total++; if (rx_dv[0] !== 1'b1) $display("FAIL m0_b2b_rx_dv got=%b exp=1", rx_dv[0]); else n_pass++;
                n_total++; if (rx_byte[0] !== exp_rx(8'h56, 8'hFF)) $display("FAIL m0_b2b_rx_byte got=%h exp=%h", rx_byte[0], exp_rx(8'h56, 8'hFF)); else n_pass++;
                n_total++; if (g_mode[0].mosi_cap !== 8'h56) $display("FAIL m0_b2b_mosi_bits got=%h exp=56", g_mode[0].mosi_cap); else n_pass++;
            end
        end
        n_total++; if (first_dv != 34) $display("FAIL m0_dv_cycle got=%0d exp=34", first_dv); else n_pass++;
    endtask

    task automatic test_modes();
        int got_k;
        got_k   = 0;
        pat     = 8'hC5;
        tx_byte = 8'hB4;
        tx_dv   = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) tx_dv = 1'b0;
            if (k == 2) begin
                n_total++; if (mosi !== 4'b0101) $display("FAIL modes_mosi_pre_edge got=%b exp=0101", mosi); else n_pass++;
            end
            if (k == 3) begin
                n_total++; if (mosi !== 4'b1111) $display("FAIL modes_mosi_lead1 got=%b exp=1111", mosi); else n_pass++;
                n_total++; if (spi_clk !== 4'b0011) $display("FAIL modes_clk_lead1 got=%b exp=0011", spi_clk); else n_pass++;
            end
            if (rx_dv[1] === 1'b1 && got_k == 0) begin
                got_k = k;
                n_total++; if (rx_dv !== 4'b1111) $display("FAIL modes_rx_dv got=%b exp=1111", rx_dv); else n_pass++;
                n_total++; if (spi_clk !== 4'b1100) $display("FAIL modes_idle_clk got=%b exp=1100", spi_clk); else n_pass++;
                n_total++; if (rx_byte[1] !== exp_rx(8'hB4, 8'hC5)) $display("FAIL mode1_rx got=%h exp=%h", rx_byte[1], exp_rx(8'hB4, 8'hC5)); else n_pass++;
                n_total++; if (rx_byte[2] !== exp_rx(8'hB4, 8'hC5)) $display("FAIL mode2_rx got=%h exp=%h", rx_byte[2], exp_rx(8'hB4, 8'hC5)); else n_pass++;
                n_total++; if (rx_byte[3] !== exp_rx(8'hB4, 8'hC5)) $display("FAIL mode3_rx got=%h exp=%h", rx_byte[3], exp_rx(8'hB4, 8'hC5)); else n_pass++;
                n_total++; if (g_mode[1].mosi_cap !== 8'hB4) $display("FAIL mode1_mosi got=%h exp=b4", g_mode[1].mosi_cap); else n_pass++;
                n_total++; if (g_mode[2].mosi_cap !== 8'hB4) $display("FAIL mode2_mosi got=%h exp=b4", g_mode[2].mosi_cap); else n_pass++;
                n_total++; if (g_mode[3].mosi_cap !== 8'hB4) $display("FAIL mode3_mosi got=%h exp=b4", g_mode[3].mosi_cap); else n_pass++;
            end
        end
        n_total++; if (got_k != 34) $display("FAIL modes_dv_cycle got=%0d exp=34", got_k); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int         dv_count;
        logic [7:0] rx_snap;
        logic [7:0] mosi_snap;
        dv_count  = 0;
        rx_snap   = 8'hxx;
        mosi_snap = 8'hxx;
        pat       = 8'h00;
        tx_byte   = 8'h11;
        tx_dv     = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) tx_dv = 1'b0;
            if (k == 10) begin tx_byte = 8'h22; tx_dv = 1'b1; end
            if (k == 11) tx_dv = 1'b0;
            if (rx_dv[0] === 1'b1) begin
                dv_count++;
                rx_snap   = rx_byte[0];
                mosi_snap = g_mode[0].mosi_cap;
            end
        end
        n_total++; if (dv_count != 1) $display("FAIL busy_dv_count got=%0d exp=1", dv_count); else n_pass++;
        n_total++; if (rx_snap !== exp_rx(8'h11, 8'h00)) $display("FAIL busy_rx got=%h exp=%h", rx_snap, exp_rx(8'h11, 8'h00)); else n_pass++;
        n_total++; if (mosi_snap !== 8'h11) $display("FAIL busy_mosi got=%h exp=11", mosi_snap); else n_pass++;
        n_total++; if (tx_ready !== 4'b1111) $display("FAIL busy_ready_end got=%b exp=1111", tx_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   edges_pre;
        int   edges_post;
        int   dv_count;
        logic prev;
        edges_pre  = 0;
        edges_post = 0;
        dv_count   = 0;
        prev       = spi_clk[0];
        pat        = 8'hFF;
        tx_byte    = 8'h96;
        tx_dv      = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) tx_dv = 1'b0;
            if (spi_clk[0] !== prev) begin
                if (k <= 11) edges_pre++;
                else if (k >= 13) edges_post++;
            end
            prev = spi_clk[0];
            if (rx_dv !== 4'b0000) dv_count++;
            if (k == 11) begin
                n_total++; if (edges_pre != 5) $display("FAIL rmid_edges_before got=%0d exp=5", edges_pre); else n_pass++;
                rst = 1'b1;
            end
            if (k == 12) begin
                n_total++; if (spi_clk !== 4'b1100) $display("FAIL rmid_clk got=%b exp=1100", spi_clk); else n_pass++;
                n_total++; if (tx_ready !== 4'b0000) $display("FAIL rmid_ready got=%b exp=0000", tx_ready); else n_pass++;
            end
            if (k == 14) rst = 1'b0;
            if (k == 15) begin
                n_total++; if (tx_ready !== 4'b1111) $display("FAIL rmid_release_ready got=%b exp=1111", tx_ready); else n_pass++;
            end
        end
        n_total++; if (dv_count != 0) $display("FAIL rmid_no_dv got=%0d exp=0", dv_count); else n_pass++;
        n_total++; if (edges_post != 0) $display("FAIL rmid_no_edges got=%0d exp=0", edges_post); else n_pass++;
    endtask

    task automatic test_loopback();
        int got_k;
        got_k   = 0;
        pat     = 8'h00;
        tx_byte = 8'h3C;
        tx_dv   = 1'b1;
        for (int k = 1; k <= 60 && got_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) tx_dv = 1'b0;
            if (rx_dv[0] === 1'b1) got_k = k;
        end
        n_total++; if (got_k == 0) $display("FAIL lb_timeout got=none exp=rx_dv"); else n_pass++;
        n_total++; if (rx_byte[0] !== exp_rx(8'h3C, 8'h00)) $display("FAIL lb_rx0 got=%h exp=%h", rx_byte[0], exp_rx(8'h3C, 8'h00)); else n_pass++;
        n_total++; if (rx_byte[3] !== exp_rx(8'h3C, 8'h00)) $display("FAIL lb_rx3 got=%h exp=%h", rx_byte[3], exp_rx(8'h3C, 8'h00)); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        pat     = 8'h00;
        test_reset();
        test_mode0_back_to_back();
        repeat (2) @(negedge clk);
        test_modes();
        test_busy_ignore();
        test_reset_mid();
        repeat (2) @(negedge clk);
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
